uart_tx_input_fifo: RTL and testbench

Parametrised transmit-side input buffer for the UART transmitter. It accepts words from the host on a write strobe and holds them in a DEPTH-entry FIFO. The head word is presented to the transmitter FSM with a valid/take handshake. It supports back-to-back host writes while a frame is on the line, reports fill level, and keeps a sticky overflow flag.

---
 rtl/uart_tx_input_fifo_if.sv | 47 ++++
 rtl/uart_tx_input_fifo.sv | 137 +++++++++++++
 tb/tb_uart_tx_input_fifo.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_input_fifo_if.sv
// Host/transmitter bus of the UART transmit input FIFO.
// The slave modport is the FIFO itself. The master modport is the side that
// drives writes and takes words: the host and the transmitter FSM.
// Optional build macro: UART_TX_FIFO_ALMOST_FULL_EN adds almost_full_o.
//
// Handshake: the head word on data_o is offered while valid_o=1. The
// transmitter takes it by pulsing rd_i. A take happens only on a rising edge
// where rd_i=1 and valid_o=1. rd_i while valid_o=0 is ignored.
// Writes use no handshake. wr_i=1 offers data_i on that edge. The word is
// stored if there is room, or if a take happens on the same edge. Otherwise
// it is dropped and the drop is recorded in overflow_o.
interface uart_tx_input_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] data_i;
    logic              wr_i;
    logic              rd_i;
    logic              flush_i;
    logic              clr_ovf_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              full_o;
    logic [LW-1:0]     level_o;
    logic              overflow_o;
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    logic              almost_full_o;
`endif

    modport master (
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
        input  almost_full_o,
`endif
        output data_i, wr_i, rd_i, flush_i, clr_ovf_i,
        input  data_o, valid_o, full_o, level_o, overflow_o
    );

    modport slave (
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
        output almost_full_o,
`endif
        input  data_i, wr_i, rd_i, flush_i, clr_ovf_i,
        output data_o, valid_o, full_o, level_o, overflow_o
    );
endinterface

// File: rtl/uart_tx_input_fifo.sv
// Transmit-side input FIFO for the UART transmitter.
// The FIFO holds DEPTH words. data_o shows the head word directly
// (first-word fall-through). data_o, level_o, valid_o, full_o and
// overflow_o are all registered.
// Optional build macro: UART_TX_FIFO_ALMOST_FULL_EN adds a registered
// almost_full_o flag that is set while level >= AF_THRESH.
module uart_tx_input_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic                 clk_i,
    input  logic                 rstb_i,
    uart_tx_input_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Reject configurations the pointer arithmetic cannot support.
    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_input_fifo: DATA_W must be 5..9");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_input_fifo: DEPTH must be a power of two >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("uart_tx_input_fifo: AF_THRESH must be 1..DEPTH");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [LW-1:0]     level_after_rd;
    logic              valid_q, full_q, ovf_q, ovf_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rd_acc, wr_acc, ovf_evt;
    logic              head_from_input;

    // Decide what happens on this edge. A flush cancels both the write and the take.
    always_comb begin
        rd_acc  = 1'b0;
        wr_acc  = 1'b0;
        ovf_evt = 1'b0;
        if (!bus.flush_i) begin
            rd_acc  = bus.rd_i & valid_q;
            wr_acc  = bus.wr_i & (~full_q | rd_acc);
            ovf_evt = bus.wr_i & full_q & ~rd_acc;
        end
    end

    // Next pointers, level and head word.
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        data_d          = data_q;
        level_after_rd  = level_q - LW'(rd_acc);
        head_from_input = 1'b0;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_after_rd + LW'(wr_acc);
            // The FIFO holds no older word after the take, so the word
            // written on this edge becomes the new head.
            head_from_input = wr_acc && (level_after_rd == '0);
            if (level_d != '0) begin
                data_d = head_from_input ? bus.data_i : mem[rd_ptr_d];
            end
        end
    end

    // A new drop sets the sticky flag. If a clear arrives on the same edge, the set wins.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf_i) begin
            ovf_d = 1'b0;
        end
    end

    // Storage array. It is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[wr_ptr_q] <= bus.data_i;
    end

    // Control and status state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= (level_d != '0);
            full_q   <= (level_d == LW'(DEPTH));
            ovf_q    <= ovf_d;
            data_q   <= data_d;
        end
    end

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
    logic af_q;

    // The almost-full flag is computed from the next level, so it changes together with level_o.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (level_d >= LW'(AF_THRESH));
        end
    end

    assign bus.almost_full_o = af_q;
`endif

    assign bus.data_o     = data_q;
    assign bus.valid_o    = valid_q;
    assign bus.full_o     = full_q;
    assign bus.level_o    = level_q;
    assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx_input_fifo.sv
// Bench for uart_tx_input_fifo. A queue model is compared against the DUT
// every cycle. Directed steps also check hand-computed literal values.
module tb_uart_tx_input_fifo;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int AF_THRESH = 3;

    logic clk_i  = 1'b0;
    logic rstb_i = 1'b0;

    uart_tx_input_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    uart_tx_input_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)
    ) dut (
        .clk_i  (clk_i),
        .rstb_i (rstb_i),
        .bus    (bus)
    );

    // Clock generation.
    always #5 clk_i = ~clk_i;

    // Reference model.
    logic [DATA_W-1:0] exp_q[$];
    logic              m_ovf;
    logic [DATA_W-1:0] m_head;
    bit                cmp_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_head = '0;
    endtask

    task automatic model_step(input bit wr, input logic [DATA_W-1:0] d,
                              input bit rd, input bit fl, input bit clr);
        bit full_now, rd_ok, wr_ok, drop;
        if (fl) begin
            exp_q.delete();
            if (clr) m_ovf = 1'b0;
        end else begin
            full_now = (exp_q.size() == DEPTH);
            rd_ok    = rd && (exp_q.size() > 0);
            wr_ok    = wr && (!full_now || rd_ok);
            drop     = wr && full_now && !rd_ok;
            if (rd_ok) void'(exp_q.pop_front());
            if (wr_ok) exp_q.push_back(d);
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        if (exp_q.size() > 0) m_head = exp_q[0];
    endtask

    // Drive one cycle. Inputs change 1 time unit after the rising edge.
    task automatic step(input bit wr, input logic [DATA_W-1:0] d,
                        input bit rd, input bit fl, input bit clr);
        bus.wr_i      = wr;
        bus.data_i    = d;
        bus.rd_i      = rd;
        bus.flush_i   = fl;
        bus.clr_ovf_i = clr;
        @(posedge clk_i);
        model_step(wr, d, rd, fl, clr);
        #1;
        bus.wr_i      = 1'b0;
        bus.rd_i      = 1'b0;
        bus.flush_i   = 1'b0;
        bus.clr_ovf_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_o"}, 32'(bus.data_o), 32'h0);
        chk({tag, "_valid_o"}, 32'(bus.valid_o), 32'h0);
        chk({tag, "_full_o"}, 32'(bus.full_o), 32'h0);
        chk({tag, "_level_o"}, 32'(bus.level_o), 32'h0);
        chk({tag, "_overflow_o"}, 32'(bus.overflow_o), 32'h0);
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
        chk({tag, "_almost_full_o"}, 32'(bus.almost_full_o), 32'h0);
`endif
    endtask

    // Scoreboard: compare every output against the model on the falling edge.
    always @(negedge clk_i) begin
        if (cmp_en && rstb_i) begin
            chk("cyc_data_o", 32'(bus.data_o), 32'(m_head));
            chk("cyc_valid_o", 32'(bus.valid_o), 32'(exp_q.size() != 0));
            chk("cyc_full_o", 32'(bus.full_o), 32'(exp_q.size() == DEPTH));
            chk("cyc_level_o", 32'(bus.level_o), 32'(exp_q.size()));
            chk("cyc_overflow_o", 32'(bus.overflow_o), 32'(m_ovf));
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
            chk("cyc_almost_full_o", 32'(bus.almost_full_o), 32'(exp_q.size() >= AF_THRESH));
`endif
        end
    end

    // Watchdog so that the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus and final report.
    initial begin
        bus.data_i    = '0;
        bus.wr_i      = 1'b0;
        bus.rd_i      = 1'b0;
        bus.flush_i   = 1'b0;
        bus.clr_ovf_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        rstb_i = 1'b1;
        cmp_en = 1'b1;

        // A single word passes through.
        step(1, 8'h41, 0, 0, 0);
        chk("w41_valid", 32'(bus.valid_o), 32'h1);
        chk("w41_data", 32'(bus.data_o), 32'h41);
        chk("w41_level", 32'(bus.level_o), 32'h1);
        step(0, 8'h00, 1, 0, 0);
        chk("r41_valid", 32'(bus.valid_o), 32'h0);
        chk("r41_level", 32'(bus.level_o), 32'h0);

        // Fill the FIFO, then overflow it and drain it.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        chk("fill_full", 32'(bus.full_o), 32'h1);
        chk("fill_level", 32'(bus.level_o), 32'h4);
        step(1, 8'h14, 0, 0, 0);
        chk("ovf_set", 32'(bus.overflow_o), 32'h1);
        chk("ovf_level", 32'(bus.level_o), 32'h4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(bus.data_o), 32'(8'h10 + i));
            step(0, 8'h00, 1, 0, 0);
        end
        chk("drain_empty", 32'(bus.valid_o), 32'h0);
        chk("drain_hold", 32'(bus.data_o), 32'h13);
        step(0, 8'h00, 0, 0, 1);
        chk("ovf_clr", 32'(bus.overflow_o), 32'h0);

        // Write and take on the same edge while the FIFO is full.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        step(1, 8'h55, 1, 0, 0);
        chk("fullrw_level", 32'(bus.level_o), 32'h4);
        chk("fullrw_ovf", 32'(bus.overflow_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("fullrw_data", 32'(bus.data_o), 32'(8'h21 + i));
            step(0, 8'h00, 1, 0, 0);
        end
        chk("fullrw_last", 32'(bus.data_o), 32'h55);
        step(0, 8'h00, 1, 0, 0);

        // Write/take pairs offset by one cycle so the pointers wrap.
        step(1, 8'h00, 0, 0, 0);
        for (int i = 1; i < 10; i++) begin
            step(1, 8'(i), 1, 0, 0);
            chk("pair_data", 32'(bus.data_o), 32'(i));
            chk("pair_valid", 32'(bus.valid_o), 32'h1);
        end
        step(0, 8'h00, 1, 0, 0);
        chk("pair_empty", 32'(bus.level_o), 32'h0);

        // A flush overrides a write and a take on the same edge.
        for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
        step(1, 8'h3f, 1, 1, 0);
        chk("flush_level", 32'(bus.level_o), 32'h0);
        chk("flush_valid", 32'(bus.valid_o), 32'h0);

        // A new overflow on the same edge as a clear keeps the flag set.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
        step(1, 8'h44, 0, 0, 0);
        step(1, 8'h45, 0, 0, 1);
        chk("ovf_setwins", 32'(bus.overflow_o), 32'h1);
        step(0, 8'h00, 0, 1, 1);
        chk("ovf_clr2", 32'(bus.overflow_o), 32'h0);

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
        // The almost-full flag crosses its threshold in both directions.
        step(1, 8'h60, 0, 0, 0);
        step(1, 8'h61, 0, 0, 0);
        chk("af_at2", 32'(bus.almost_full_o), 32'h0);
        step(1, 8'h62, 0, 0, 0);
        chk("af_at3", 32'(bus.almost_full_o), 32'h1);
        step(0, 8'h00, 1, 0, 0);
        chk("af_back2", 32'(bus.almost_full_o), 32'h0);
        step(0, 8'h00, 0, 1, 0);
`endif

        // Randomized traffic, checked every cycle by the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            step(bit'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                 bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 3),
                 bit'($urandom_range(0, 99) < 5));
        end

        // Reset in the middle of traffic clears everything at once.
        for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0, 0, 0);
        step(1, 8'h73, 0, 0, 0);
        step(1, 8'h74, 0, 0, 0);
        #2;
        rstb_i = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(posedge clk_i);
        #1;
        rstb_i = 1'b1;
        step(1, 8'h5a, 0, 0, 0);
        chk("postreset_data", 32'(bus.data_o), 32'h5a);
        chk("postreset_level", 32'(bus.level_o), 32'h1);
        repeat (2) @(posedge clk_i);
        #1;

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
